// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-look-ahead adder: group width,
// group generate/propagate reduction and pipeline depth derivation.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t group_gp(input logic [GROUP_W-1:0] gen,
                                     input logic [GROUP_W-1:0] prop);
        gp_t r;
        r.g = gen[3]
            | (prop[3] & gen[2])
            | (prop[3] & prop[2] & gen[1])
            | (prop[3] & prop[2] & prop[1] & gen[0]);
        r.p = &prop;
        return r;
    endfunction

    function automatic int num_stages(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction

endpackage

// File: rtl/cla_group.sv
// 4-bit combinational look-ahead group: sum bits plus group generate/propagate.
// g and p never depend on ci, so the slice-level look-ahead has no loop.
module cla_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               g,
    output logic               p
);

    logic [GROUP_W-1:0] gen;
    logic [GROUP_W-1:0] prop;
    logic [GROUP_W-1:0] c;
    gp_t                gp;

    assign gen  = a & b;
    assign prop = a ^ b;

    assign c[0] = ci;
    assign c[1] = gen[0] | (prop[0] & ci);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & ci);

    assign s  = prop ^ c;
    assign gp = group_gp(gen, prop);
    assign g  = gp.g;
    assign p  = gp.p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: an acceptance register followed by one
// register per SLICE-wide stage, all advancing together under backpressure.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int GPS     = GROUPS_PER_STAGE;
    localparam int SLICE   = GROUP_W * GPS;
    localparam int NSTAGES = num_stages(WIDTH, GPS);

    if ((WIDTH % SLICE) != 0 || NSTAGES < 1) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of 4*GROUPS_PER_STAGE");
    end

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // acceptance boundary: b is inverted here so the pipe only ever adds
    logic             vld_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             c_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     vld_p0 <= 1'b0;
        else if (en) vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_p0 <= a;
            b_p0 <= b ^ {WIDTH{sub}};
            c_p0 <= sub | cin;
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE;
        localparam int REM = WIDTH - LO;

        logic               vld_d;
        logic [REM-1:0]     a_d;
        logic [REM-1:0]     b_d;
        logic               c_d;
        logic [LO+SLICE-1:0] s_next;
        logic [GPS-1:0]     gg;
        logic [GPS-1:0]     gp;
        logic [GPS:0]       gc;
        logic [SLICE-1:0]   slice_s;

        if (k == 0) begin : g_head
            assign vld_d  = vld_p0;
            assign a_d    = a_p0;
            assign b_d    = b_p0;
            assign c_d    = c_p0;
            assign s_next = slice_s;
        end else begin : g_chain
            assign vld_d  = g_stage[k-1].g_pass.vld_p;
            assign a_d    = g_stage[k-1].g_pass.a_p;
            assign b_d    = g_stage[k-1].g_pass.b_p;
            assign c_d    = g_stage[k-1].g_pass.c_p;
            assign s_next = {slice_s, g_stage[k-1].g_pass.s_p};
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_group u_grp (
                .a  (a_d[j*GROUP_W +: GROUP_W]),
                .b  (b_d[j*GROUP_W +: GROUP_W]),
                .ci (gc[j]),
                .s  (slice_s[j*GROUP_W +: GROUP_W]),
                .g  (gg[j]),
                .p  (gp[j])
            );
        end

        // each group carry is a flat sum of products of G/P terms and c_d
        always_comb begin : p_lookahead
            logic t;
            gc    = '0;
            t     = 1'b0;
            gc[0] = c_d;
            for (int j = 1; j <= GPS; j++) begin
                t = c_d;
                for (int m = 0; m < j; m++) t = t & gp[m];
                gc[j] = t;
                for (int i = 0; i < j; i++) begin
                    t = gg[i];
                    for (int m = i + 1; m < j; m++) t = t & gp[m];
                    gc[j] = gc[j] | t;
                end
            end
        end

        if (k < NSTAGES - 1) begin : g_pass
            logic                vld_p;
            logic [REM-SLICE-1:0] a_p;
            logic [REM-SLICE-1:0] b_p;
            logic [LO+SLICE-1:0] s_p;
            logic                c_p;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)     vld_p <= 1'b0;
                else if (en) vld_p <= vld_d;
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    a_p <= a_d[REM-1:SLICE];
                    b_p <= b_d[REM-1:SLICE];
                    s_p <= s_next;
                    c_p <= gc[GPS];
                end
            end
        end else begin : g_last
            // carry into the MSB recovered from the MSB sum bit
            logic c_msb;
            assign c_msb = slice_s[SLICE-1] ^ a_d[SLICE-1] ^ b_d[SLICE-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (en) begin
                    out_valid <= vld_d;
                    sum       <= s_next;
                    cout      <= gc[GPS];
                    ovf       <= c_msb ^ gc[GPS];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomised checks of pipelined_cla_adder in four configurations.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // directed instance, WIDTH=16 GPS=2
    logic        d_in_valid = 1'b0, d_in_ready, d_cin = 1'b0, d_sub = 1'b0;
    logic        d_out_valid, d_out_ready = 1'b1, d_cout, d_ovf;
    logic [15:0] d_a = '0, d_b = '0, d_sum;

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
    );

    // sweep instances share operand/ready stimulus; only the selected one gets in_valid
    logic [31:0] sw_a = '0, sw_b = '0;
    logic [2:0]  sw_v = '0;
    logic        sw_cin = 1'b0, sw_sub = 1'b0, sw_rdy = 1'b1;
    logic        r0_rdy, r0_ov, r0_c, r0_o;
    logic        r1_rdy, r1_ov, r1_c, r1_o;
    logic        r2_rdy, r2_ov, r2_c, r2_o;
    logic [7:0]  r0_s;
    logic [15:0] r1_s;
    logic [31:0] r2_s;

    pipelined_cla_adder #(.WIDTH(8), .GROUPS_PER_STAGE(1)) dut_8_1 (
        .clk(clk), .rst(rst), .in_valid(sw_v[0]), .in_ready(r0_rdy),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(r0_ov),
        .out_ready(sw_rdy), .sum(r0_s), .cout(r0_c), .ovf(r0_o)
    );
    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(4)) dut_16_4 (
        .clk(clk), .rst(rst), .in_valid(sw_v[1]), .in_ready(r1_rdy),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(r1_ov),
        .out_ready(sw_rdy), .sum(r1_s), .cout(r1_c), .ovf(r1_o)
    );
    pipelined_cla_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut_32_2 (
        .clk(clk), .rst(rst), .in_valid(sw_v[2]), .in_ready(r2_rdy),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(r2_ov),
        .out_ready(sw_rdy), .sum(r2_s), .cout(r2_c), .ovf(r2_o)
    );

    int          sel = 0;
    logic        sel_rdy, sel_ov, sel_c, sel_o;
    logic [31:0] sel_s;

    always_comb begin
        sel_rdy = r0_rdy; sel_ov = r0_ov; sel_c = r0_c; sel_o = r0_o; sel_s = {24'b0, r0_s};
        if (sel == 1) begin
            sel_rdy = r1_rdy; sel_ov = r1_ov; sel_c = r1_c; sel_o = r1_o; sel_s = {16'b0, r1_s};
        end else if (sel == 2) begin
            sel_rdy = r2_rdy; sel_ov = r2_ov; sel_c = r2_c; sel_o = r2_o; sel_s = r2_s;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    // one transfer on the directed instance; observations at latency-1 and latency
    task automatic apply_one(input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub,
                             output logic early, output logic vld,
                             output logic [15:0] s, output logic c, output logic o);
        @(negedge clk);
        d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        @(negedge clk);
        early = d_out_valid;
        @(negedge clk);
        vld = d_out_valid; s = d_sum; c = d_cout; o = d_ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", d_out_valid); end
        n_cmp++; if (d_sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got %h want 0000", d_sum); end
        n_cmp++; if ({d_cout, d_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf got %b want 00", {d_cout, d_ovf}); end
        n_cmp++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", d_in_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({d_in_ready, d_out_valid} !== 2'b10) begin n_fail++; $display("FAIL post_reset_rdy_vld got %b want 10", {d_in_ready, d_out_valid}); end
    endtask

    task automatic test_add;
        logic [15:0] va[5], vb[5], vs[5], s;
        logic        vc[5], vco[5], vov[5], early, vld, c, o;
        va  = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h7FFF, 16'hFFFF};
        vb  = '{16'h4321, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF};
        vc  = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
        vs  = '{16'h5555, 16'h0000, 16'h0100, 16'h8000, 16'hFFFF};
        vco = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        vov = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
        for (int i = 0; i < 5; i++) begin
            apply_one(va[i], vb[i], vc[i], 1'b0, early, vld, s, c, o);
            n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL add_latency[%0d] out_valid early got %b want 0", i, early); end
            n_cmp++;
            if ({vld, s, c, o} !== {1'b1, vs[i], vco[i], vov[i]}) begin
                n_fail++;
                $display("FAIL add[%0d] got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                         i, vld, s, c, o, vs[i], vco[i], vov[i]);
            end
        end
    endtask

    task automatic test_sub;
        logic [15:0] va[3], vb[3], vs[3], s;
        logic        vc[3], vco[3], vov[3], early, vld, c, o;
        va  = '{16'h8000, 16'h0003, 16'h0005};
        vb  = '{16'h0001, 16'h0005, 16'h0005};
        vc  = '{1'b0,     1'b1,     1'b0};
        vs  = '{16'h7FFF, 16'hFFFE, 16'h0000};
        vco = '{1'b1,     1'b0,     1'b1};
        vov = '{1'b1,     1'b0,     1'b0};
        for (int i = 0; i < 3; i++) begin
            apply_one(va[i], vb[i], vc[i], 1'b1, early, vld, s, c, o);
            n_cmp++;
            if ({vld, s, c, o} !== {1'b1, vs[i], vco[i], vov[i]}) begin
                n_fail++;
                $display("FAIL sub[%0d] got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                         i, vld, s, c, o, vs[i], vco[i], vov[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] va[3], vb[3], vs[3];
        logic        vco[3], vov[3];
        va  = '{16'h0001, 16'h1000, 16'h4000};
        vb  = '{16'h0002, 16'hF000, 16'h4000};
        vs  = '{16'h0003, 16'h0000, 16'h8000};
        vco = '{1'b0, 1'b1, 1'b0};
        vov = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_a = va[i]; d_b = vb[i]; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
        end
        @(negedge clk);
        d_in_valid = 1'b0; d_out_ready = 1'b0;
        #1;
        for (int t = 0; t < 2; t++) begin
            n_cmp++;
            if ({d_in_ready, d_out_valid, d_sum, d_cout, d_ovf} !== {1'b0, 1'b1, vs[0], vco[0], vov[0]}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got rdy=%b v=%b sum=%h c=%b o=%b want rdy=0 v=1 sum=%h c=%b o=%b",
                         t, d_in_ready, d_out_valid, d_sum, d_cout, d_ovf, vs[0], vco[0], vov[0]);
            end
            if (t == 0) @(negedge clk);
        end
        d_out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({d_out_valid, d_sum, d_cout, d_ovf} !== {1'b1, vs[i], vco[i], vov[i]}) begin
                n_fail++;
                $display("FAIL b2b_order[%0d] got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                         i, d_out_valid, d_sum, d_cout, d_ovf, vs[i], vco[i], vov[i]);
            end
        end
        @(negedge clk);
        n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup out_valid got %b want 0", d_out_valid); end
    endtask

    task automatic test_reset_mid;
        logic        stale, early, vld, c, o;
        logic [15:0] s;
        @(negedge clk);
        d_a = 16'h1111; d_b = 16'h2222; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        d_a = 16'h0F0F; d_b = 16'h0101;
        @(negedge clk);
        d_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({d_out_valid, d_sum} !== {1'b1, 16'h3333}) begin n_fail++; $display("FAIL pre_reset_result got v=%b sum=%h want v=1 sum=3333", d_out_valid, d_sum); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({d_out_valid, d_sum} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL async_reset got v=%b sum=%h want v=0 sum=0000", d_out_valid, d_sum); end
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (d_out_valid !== 1'b0) stale = 1'b1;
        end
        n_cmp++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_after_reset got 1 want 0"); end
        apply_one(16'h7000, 16'h1000, 1'b0, 1'b0, early, vld, s, c, o);
        n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL reset_latency early out_valid got %b want 0", early); end
        n_cmp++;
        if ({vld, s, c, o} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_xfer got v=%b sum=%h c=%b o=%b want v=1 sum=8000 c=0 o=1", vld, s, c, o);
        end
    endtask

    task automatic test_sweep(input int idx, input int w);
        logic [33:0] exp_q[$];
        logic [33:0] got, expv;
        logic [31:0] m, bb, s;
        logic [63:0] full;
        logic        va, co, ov;
        int          acc, cyc;
        m   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        sel = idx; acc = 0; cyc = 0;
        while ((acc < 1000 || exp_q.size() > 0) && cyc < 8000) begin
            @(negedge clk);
            va     = (acc < 1000) && ($urandom_range(0, 3) != 0);
            sw_a   = $urandom & m;
            sw_b   = $urandom & m;
            sw_cin = 1'($urandom_range(0, 1));
            sw_sub = 1'($urandom_range(0, 1));
            sw_v   = va ? (3'b001 << idx) : 3'b000;
            sw_rdy = (acc >= 1000) || ($urandom_range(0, 3) != 0);
            #1;
            if (sel_ov && sw_rdy) begin
                got = {sel_o, sel_c, sel_s};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep_w%0d unexpected result got %h want none", w, got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        n_fail++;
                        $display("FAIL sweep_w%0d got ovf,cout,sum=%h want %h", w, got, expv);
                    end
                end
            end
            if (va && sel_rdy) begin
                bb   = sw_sub ? (~sw_b & m) : sw_b;
                full = {32'b0, sw_a} + {32'b0, bb} + {63'b0, (sw_sub | sw_cin)};
                s    = full[31:0] & m;
                co   = full[w];
                ov   = (sw_a[w-1] == bb[w-1]) && (s[w-1] != sw_a[w-1]);
                exp_q.push_back({ov, co, s});
                acc++;
            end
            cyc++;
        end
        sw_v = 3'b000;
        sw_rdy = 1'b1;
        n_cmp++;
        if (acc != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_w%0d_complete got accepted=%0d pending=%0d want accepted=1000 pending=0",
                     w, acc, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_sweep(0, 8);
        test_sweep(1, 16);
        test_sweep(2, 32);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
